// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared widths, load-size encodings and the writeback FIFO
//               entry layout for the 32-bit core.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [1:0] LOAD_BYTE = 2'b00;
    localparam logic [1:0] LOAD_HALF = 2'b01;
    localparam logic [1:0] LOAD_WORD = 2'b10;

    typedef struct packed {
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] memdata;
        logic              memtoreg;
        logic              regwrite;
        logic [1:0]        size;
        logic              is_unsigned;
        logic [1:0]        offset;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects the byte/half lane of a loaded word and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import core_pkg::*;
(
    input  logic [DATA_W-1:0] mem_data,
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic        ext_byte;
    logic        ext_half;

    always_comb begin
        lane_byte = mem_data[7:0];
        case (offset)
            2'd1:    lane_byte = mem_data[15:8];
            2'd2:    lane_byte = mem_data[23:16];
            2'd3:    lane_byte = mem_data[31:24];
            default: lane_byte = mem_data[7:0];
        endcase
        // Half-word lane uses only offset[1]; a misaligned offset[0] is ignored.
        lane_half = offset[1] ? mem_data[31:16] : mem_data[15:0];
        ext_byte  = !is_unsigned && lane_byte[7];
        ext_half  = !is_unsigned && lane_half[15];

        data = mem_data;
        case (size)
            LOAD_BYTE: data = {{(DATA_W-8){ext_byte}}, lane_byte};
            LOAD_HALF: data = {{(DATA_W-16){ext_half}}, lane_half};
            default:   data = mem_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Final pipeline stage: buffers retiring instructions in a small
//               FIFO and drives the register-file write port, one per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              InValid,
    output logic              InReady,
    input  logic [REG_W-1:0]  InDestReg,
    input  logic [DATA_W-1:0] InAluResult,
    input  logic [DATA_W-1:0] InMemData,
    input  logic              InMemToReg,
    input  logic              InRegWrite,
    input  logic [1:0]        InLoadSize,
    input  logic              InLoadUnsigned,
    input  logic              Flush,
    input  logic              WbStall,
    output logic [REG_W-1:0]  WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite,
    output logic [CNT_W-1:0]  RetireCount
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(DEPTH);

    wb_entry_t         fifo_mem [DEPTH];
    wb_entry_t         in_entry;
    wb_entry_t         head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  count;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] aligned;

    // Ready depends only on occupancy so a pop never feeds back into it.
    assign InReady = Rst_n && (count < FULL_COUNT);
    assign push    = InValid && InReady && !Flush;
    assign pop     = (count != '0) && !WbStall && !Flush;

    always_comb begin
        in_entry.dest        = InDestReg;
        in_entry.alu         = InAluResult;
        in_entry.memdata     = InMemData;
        in_entry.memtoreg    = InMemToReg;
        in_entry.regwrite    = InRegWrite;
        in_entry.size        = InLoadSize;
        in_entry.is_unsigned = InLoadUnsigned;
        in_entry.offset      = InAluResult[1:0];
    end

    assign head = fifo_mem[rd_ptr];

    load_align u_load_align (
        .mem_data    (head.memdata),
        .size        (head.size),
        .offset      (head.offset),
        .is_unsigned (head.is_unsigned),
        .data        (aligned)
    );

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + OCC_W'(1);
            end else if (pop && !push) begin
                count <= count - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            WriteRegister <= '0;
            WriteData     <= '0;
            RegWrite      <= 1'b0;
            RetireCount   <= '0;
        end else begin
            RegWrite <= 1'b0;
            if (pop) begin
                WriteRegister <= head.dest;
                WriteData     <= head.memtoreg ? aligned : head.alu;
                // Writes to $0 retire normally but never reach the register file.
                RegWrite      <= head.regwrite && (head.dest != '0);
                RetireCount   <= RetireCount + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Directed self-checking bench for writeback_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        InValid;
    logic        InReady;
    logic [4:0]  InDestReg;
    logic [31:0] InAluResult;
    logic [31:0] InMemData;
    logic        InMemToReg;
    logic        InRegWrite;
    logic [1:0]  InLoadSize;
    logic        InLoadUnsigned;
    logic        Flush;
    logic        WbStall;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [31:0] RetireCount;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    writeback_stage #(.DEPTH(2), .CNT_W(32)) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .InValid        (InValid),
        .InReady        (InReady),
        .InDestReg      (InDestReg),
        .InAluResult    (InAluResult),
        .InMemData      (InMemData),
        .InMemToReg     (InMemToReg),
        .InRegWrite     (InRegWrite),
        .InLoadSize     (InLoadSize),
        .InLoadUnsigned (InLoadUnsigned),
        .Flush          (Flush),
        .WbStall        (WbStall),
        .WriteRegister  (WriteRegister),
        .WriteData      (WriteData),
        .RegWrite       (RegWrite),
        .RetireCount    (RetireCount)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] d, input logic [31:0] alu, input logic [31:0] mem,
                         input logic m2r, input logic rw, input logic [1:0] sz, input logic uns);
        InValid        = 1'b1;
        InDestReg      = d;
        InAluResult    = alu;
        InMemData      = mem;
        InMemToReg     = m2r;
        InRegWrite     = rw;
        InLoadSize     = sz;
        InLoadUnsigned = uns;
    endtask

    // Load alignment vectors: address, size, unsigned, expected result.
    logic [31:0] av_addr [8] = '{32'h100, 32'h101, 32'h102, 32'h103,
                                 32'h102, 32'h100, 32'h100, 32'h101};
    logic [1:0]  av_size [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
    logic        av_uns  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] av_exp  [8] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80,
                                 32'h000080FF, 32'h00007F01, 32'h80FF7F01, 32'h80FF7F01};

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Rst_n = 1'b0;
        InValid = 1'b0; InDestReg = '0; InAluResult = '0; InMemData = '0;
        InMemToReg = 1'b0; InRegWrite = 1'b0; InLoadSize = '0; InLoadUnsigned = 1'b0;
        Flush = 1'b0; WbStall = 1'b0;
        tick();
        check("rst_ready", 32'(InReady), 32'd0);
        check("rst_regwrite", 32'(RegWrite), 32'd0);
        check("rst_wreg", 32'(WriteRegister), 32'd0);
        check("rst_wdata", WriteData, 32'd0);
        check("rst_retire", RetireCount, 32'd0);
        tick();
        Rst_n = 1'b1;
        tick();
        check("ready_after_rst", 32'(InReady), 32'd1);

        // Single ALU write: visible only after the second edge.
        offer(5'd5, 32'h12345678, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
        tick();
        InValid = 1'b0;
        check("alu_lat_n", 32'(RegWrite), 32'd0);
        tick();
        check("alu_regwrite", 32'(RegWrite), 32'd1);
        check("alu_wreg", 32'(WriteRegister), 32'd5);
        check("alu_wdata", WriteData, 32'h12345678);
        check("alu_retire", RetireCount, 32'd1);
        tick();
        check("alu_pulse_end", 32'(RegWrite), 32'd0);
        check("alu_hold", WriteData, 32'h12345678);

        for (int i = 0; i < 8; i++) begin
            offer(5'd7, av_addr[i], 32'h80FF7F01, 1'b1, 1'b1, av_size[i], av_uns[i]);
            tick();
            InValid = 1'b0;
            tick();
            check($sformatf("align_%0d", i), WriteData, av_exp[i]);
            check($sformatf("align_we_%0d", i), 32'(RegWrite), 32'd1);
        end
        check("align_retire", RetireCount, 32'd9);

        // $0 destination retires without a write.
        offer(5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
        tick();
        InValid = 1'b0;
        tick();
        check("zero_regwrite", 32'(RegWrite), 32'd0);
        check("zero_retire", RetireCount, 32'd10);

        // Backpressure: third offer refused while stalled and full.
        WbStall = 1'b1;
        offer(5'd1, 32'h11, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
        tick();
        offer(5'd2, 32'h22, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
        tick();
        offer(5'd3, 32'h33, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
        check("bp_full_ready", 32'(InReady), 32'd0);
        tick();
        check("bp_still_full", 32'(InReady), 32'd0);
        check("bp_stall_we", 32'(RegWrite), 32'd0);
        InValid = 1'b0;
        WbStall = 1'b0;
        tick();
        check("bp_first_we", 32'(RegWrite), 32'd1);
        check("bp_first_reg", 32'(WriteRegister), 32'd1);
        check("bp_first_data", WriteData, 32'h11);
        check("bp_ready_back", 32'(InReady), 32'd1);
        tick();
        check("bp_second_we", 32'(RegWrite), 32'd1);
        check("bp_second_reg", 32'(WriteRegister), 32'd2);
        tick();
        check("bp_no_third", 32'(RegWrite), 32'd0);
        check("bp_retire", RetireCount, 32'd12);

        // Flush with two buffered and one offered.
        WbStall = 1'b1;
        offer(5'd4, 32'h44, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
        tick();
        offer(5'd5, 32'h55, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
        tick();
        offer(5'd6, 32'h66, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
        Flush = 1'b1;
        tick();
        Flush = 1'b0; InValid = 1'b0; WbStall = 1'b0;
        check("fl_ready", 32'(InReady), 32'd1);
        check("fl_we0", 32'(RegWrite), 32'd0);
        tick();
        check("fl_we1", 32'(RegWrite), 32'd0);
        tick();
        check("fl_we2", 32'(RegWrite), 32'd0);
        check("fl_retire", RetireCount, 32'd12);

        // Offer accepted-looking but coincident with Flush must be dropped.
        offer(5'd8, 32'h88, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
        Flush = 1'b1;
        tick();
        Flush = 1'b0; InValid = 1'b0;
        tick();
        check("fl_drop_we", 32'(RegWrite), 32'd0);
        tick();
        check("fl_drop_we2", 32'(RegWrite), 32'd0);
        check("fl_drop_retire", RetireCount, 32'd12);

        // Back-to-back stream: simultaneous push and pop.
        offer(5'd10, 32'hA, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
        tick();
        check("st_lat", 32'(RegWrite), 32'd0);
        offer(5'd11, 32'hB, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
        tick();
        check("st_h_reg", 32'(WriteRegister), 32'd10);
        check("st_h_ready", 32'(InReady), 32'd1);
        offer(5'd12, 32'hC, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
        tick();
        check("st_i_reg", 32'(WriteRegister), 32'd11);
        check("st_i_we", 32'(RegWrite), 32'd1);
        InValid = 1'b0;
        tick();
        check("st_j_reg", 32'(WriteRegister), 32'd12);
        check("st_j_data", WriteData, 32'hC);
        check("st_retire", RetireCount, 32'd15);

        // Asynchronous reset with a full FIFO.
        WbStall = 1'b1;
        offer(5'd13, 32'hD, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
        tick();
        offer(5'd14, 32'hE, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
        tick();
        InValid = 1'b0;
        check("ar_full", 32'(InReady), 32'd0);
        #2;
        Rst_n = 1'b0;
        #1;
        check("ar_wreg", 32'(WriteRegister), 32'd0);
        check("ar_wdata", WriteData, 32'd0);
        check("ar_retire", RetireCount, 32'd0);
        check("ar_ready", 32'(InReady), 32'd0);
        tick();
        Rst_n = 1'b1;
        WbStall = 1'b0;
        tick();
        check("ar_we0", 32'(RegWrite), 32'd0);
        check("ar_ready_back", 32'(InReady), 32'd1);
        tick();
        check("ar_we1", 32'(RegWrite), 32'd0);
        check("ar_retire_post", RetireCount, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the 32-bit MIPS-style core. Sits directly upstream of the 32x32 register file and drives its write port (WriteRegister, WriteData, RegWrite).
- Accepts retiring instructions from the MEM stage over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Selects the ALU result or the aligned load data as the write value, and issues at most one register write per clock.

Parameters:
- DEPTH, 2, FIFO entries (power of two, >=2).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst_n  in  1  asynchronous active-low reset.
- InValid  in  1  MEM stage presents an instruction.
- InReady  out  1  stage can accept an instruction this cycle.
- InDestReg  in  5  destination register index.
- InAluResult  in  32  ALU result; also the load address, whose low 2 bits select the byte lane.
- InMemData  in  32  raw word read from data memory.
- InMemToReg  in  1  1 = write load data, 0 = write ALU result.
- InRegWrite  in  1  instruction writes a register.
- InLoadSize  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- InLoadUnsigned  in  1  1 = zero-extend, 0 = sign-extend.
- Flush  in  1  discard all buffered instructions.
- WbStall  in  1  hold: no FIFO pop this cycle.
- WriteRegister  out  5  register file write index.
- WriteData  out  32  register file write data.
- RegWrite  out  1  register file write enable, one-cycle pulse per write.
- RetireCount  out  CNT_W  number of instructions retired.

Behaviour:
- Reset (Rst_n=0, asynchronous): FIFO empty, WriteRegister=0, WriteData=0, RegWrite=0, RetireCount=0. InReady is 0 while Rst_n=0.
- Push rule:
  - Accept when InValid && InReady, where InReady = (count < DEPTH).
  - InReady is registered-state only; it has no combinational path from WbStall or the pop decision.
  - When full, InReady=0 even if a pop occurs in the same cycle.
- FIFO fields stored per entry: dest, alu, memdata, memtoreg, regwrite, size, unsigned, offset (= InAluResult[1:0]).
- Pop rule:
  - Pop when count>0 && !WbStall && !Flush.
  - On the pop edge, register the outputs from the head entry:
    - WriteRegister = dest.
    - WriteData = memtoreg ? aligned load : alu.
    - RegWrite = regwrite && (dest != 0).
  - RetireCount increments by 1 and wraps at 2^CNT_W.
  - Entries with regwrite=0 or dest=0 still retire and still count.
- If there is no pop, RegWrite=0 on the next edge. WriteRegister and WriteData hold their last values.
- Load alignment:
  - Byte: lane = offset[1:0] (lane 0 = bits 7:0).
  - Half: lane = offset[1] (0 = bits 15:0); offset[0] is ignored.
  - Word and reserved: all 32 bits.
  - Byte and half results are sign- or zero-extended to 32 bits per `unsigned`.
- Latency, empty FIFO: instruction accepted at edge N is popped at edge N+1. RegWrite is high in cycle N+1..N+2, and the register file writes it at edge N+2. Throughput is 1 instruction/clock.
- Simultaneous push and pop: both occur; count is unchanged. A push into an empty FIFO is not popped on the same edge.
- Ordering: strict FIFO; outputs are never reordered.
- Flush:
  - At the next edge, count=0 and RegWrite=0; RetireCount is unchanged.
  - An instruction offered in the same cycle as Flush is dropped, even if InValid && InReady.
  - Flush has priority over WbStall.
- WbStall: freezes the FIFO (pushes are still allowed while not full). RegWrite=0 during stall cycles.
- Reset asserted mid-operation: all state clears immediately; in-flight entries are lost with no write issued.

Decomposition:
- Shared package core_pkg holds:
  - LOAD_BYTE / LOAD_HALF / LOAD_WORD size encodings.
  - Register index width (5) and data width (32).
- Natural sub-module load_align: combinational lane select plus extension. Inputs: memdata, size, offset, unsigned. Output: 32-bit data.
- The FIFO stays inline.

Test Plan:
- Reset then single ALU write: dest=5, alu=0x12345678, memtoreg=0 accepted at edge N -> RegWrite=1, WriteRegister=5, WriteData=0x12345678 after edge N+1 only; RetireCount=1.
- Load alignment: memdata=0x80FF7F01 with byte offsets 0..3 signed -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. Half offset 2 unsigned -> 0x000080FF. Half offset 0 signed -> 0x00007F01. Word -> 0x80FF7F01.
- $0 suppression: dest=0, regwrite=1 -> RegWrite stays 0; RetireCount still increments.
- Backpressure: WbStall=1 while offering 3 instructions -> InReady drops after 2 accepts. Release stall -> writes emerge in order on consecutive cycles and InReady re-asserts.
- Flush with 2 buffered plus 1 offered in the same cycle -> no RegWrite pulses follow, InReady=1 next cycle, RetireCount unchanged.
- Rst_n pulsed low mid-cycle with a full FIFO -> outputs go to 0 immediately (before the next edge); no write issues after release.
